// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter for fetch (I) and load/store (D)
// Registered request/response handshake with D priority and a streak limit that protects fetches.
module unified_mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ready,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ready,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ready
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner;       // 1 = D owns the memory, 0 = I
  logic [SW-1:0] streak;
  logic          grant_i;
  logic          grant_d;
  logic          done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_i || grant_d) state_nxt = BUSY;
      BUSY:    if (mem_ready) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Arbitration only happens in IDLE, so a request still held during RESP is never re-issued there.
  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    done    = 1'b0;
    if (state == IDLE) begin
      grant_d = d_req && !(i_req && (streak == STREAK_MAX));
      grant_i = i_req && !grant_d;
    end
    if (state == BUSY) begin
      done = mem_ready;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      streak    <= '0;
      owner     <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (grant_d || grant_i) begin
        mem_req   <= 1'b1;
        owner     <= grant_d;
        mem_addr  <= grant_d ? d_addr : i_addr;
        mem_we    <= grant_d && d_we;
        mem_wdata <= grant_d ? d_wdata : '0;
        mem_be    <= grant_d ? d_be : '1;
        if (grant_d && i_req) begin
          streak <= (streak == STREAK_MAX) ? streak : streak + 1'b1;
        end else begin
          streak <= '0;
        end
      end
      if (done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
        if (owner) begin
          d_rdata <= mem_rdata;
          d_ready <= 1'b1;
        end else begin
          i_rdata <= mem_rdata;
          i_ready <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
// Table of single accesses followed by hand-written arbitration, starvation, stale-request and reset sequences.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_D_STREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    int          waits;
    logic        exp_we;
    logic [3:0]  exp_be;
    int          exp_lat;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  int checks = 0;
  int failures = 0;
  bit both_hi = 1'b0;

  always @(negedge clk) if (i_ready && d_ready) both_hi = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drain();
    i_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b1;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        v;
    int          cyc, busy, waits_left, ng, prev, d_cyc, i_cyc;
    bit          done, stable;
    logic [31:0] snap_addr, held_i, held_d;
    int          got [10];
    int          gcyc [10];
    logic        mr [5];

    vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'h0050_0113, 0, 1'b0, 4'hF, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 4'h3, 32'hA5A5_A5A5, 0, 1'b1, 4'h3, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_3004, 32'h1234_5678, 4'hF, 32'hCAFE_F00D, 3, 1'b0, 4'hF, 5};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h5555_5555, 4'h2, 32'h0000_0013, 1, 1'b0, 4'hF, 3};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 4'h8, 32'h0000_0077, 2, 1'b1, 4'h8, 4};

    reset = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_readys", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_streak", 32'(dut.streak), 32'd0);
    reset = 1'b0;
    held_i = '0;
    held_d = '0;

    for (int k = 0; k < NV; k++) begin
      v = vecs[k];
      @(negedge clk);
      i_req = !v.is_d; i_addr = v.addr;
      d_req = v.is_d; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_be = v.be;
      mem_rdata = v.rdata; mem_ready = 1'b0;
      cyc = 0; busy = 0; waits_left = v.waits; done = 1'b0; stable = 1'b1; snap_addr = '0;
      while (!done && cyc < 20) begin
        @(negedge clk);
        cyc++;
        if (v.is_d ? d_ready : i_ready) begin
          done = 1'b1;
        end else if (mem_req) begin
          busy++;
          if (busy == 1) begin
            chk($sformatf("v%0d_mem_addr", k), mem_addr, v.addr);
            chk($sformatf("v%0d_mem_we", k), {31'd0, mem_we}, {31'd0, v.exp_we});
            chk($sformatf("v%0d_mem_be", k), {28'd0, mem_be}, {28'd0, v.exp_be});
            if (v.is_d) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, v.wdata);
            snap_addr = mem_addr;
            i_addr = ~v.addr;
            d_addr = ~v.addr;
            d_be = ~v.be;
          end else if (mem_addr !== snap_addr || mem_be !== v.exp_be) begin
            stable = 1'b0;
          end
          mem_ready = (waits_left == 0);
          if (waits_left > 0) waits_left--;
        end
      end
      chk($sformatf("v%0d_latency", k), cyc, v.exp_lat);
      chk($sformatf("v%0d_busy_cycles", k), busy, v.waits + 1);
      chk($sformatf("v%0d_stable", k), {31'd0, stable}, 32'd1);
      if (v.is_d) begin
        chk($sformatf("v%0d_d_rdata", k), d_rdata, v.rdata);
        chk($sformatf("v%0d_i_ready_low", k), {31'd0, i_ready}, 32'd0);
        chk($sformatf("v%0d_i_rdata_hold", k), i_rdata, held_i);
        held_d = v.rdata;
      end else begin
        chk($sformatf("v%0d_i_rdata", k), i_rdata, v.rdata);
        chk($sformatf("v%0d_d_ready_low", k), {31'd0, d_ready}, 32'd0);
        chk($sformatf("v%0d_d_rdata_hold", k), d_rdata, held_d);
        held_i = v.rdata;
      end
      i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_ready_one_cycle", k), {30'd0, i_ready, d_ready}, 32'd0);
      chk($sformatf("v%0d_idle_mem_req", k), {31'd0, mem_req}, 32'd0);
    end

    // Simultaneous requests: D first, I in the IDLE after RESP.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'h3;
    mem_rdata = 32'h1111_2222; mem_ready = 1'b1;
    cyc = 0; d_cyc = 0; i_cyc = 0;
    while (i_cyc == 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("sim_first_we", {31'd0, mem_we}, 32'd1);
        chk("sim_first_be", {28'd0, mem_be}, 32'h3);
        chk("sim_first_addr", mem_addr, 32'h0000_2000);
      end
      if (d_ready) begin d_cyc = cyc; d_req = 1'b0; end
      if (i_ready) begin i_cyc = cyc; i_req = 1'b0; end
    end
    chk("sim_d_ready_cycle", d_cyc, 2);
    chk("sim_i_ready_cycle", i_cyc, 5);
    chk("sim_ready_gap", i_cyc - d_cyc, 3);
    drain();

    // Starvation: D and I held, expect DDDDI DDDDI.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0800; d_wdata = '0; d_be = 4'h1;
    i_req = 1'b1; i_addr = 32'h0000_0044; mem_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin got[k] = -1; gcyc[k] = 0; end
    ng = 0; cyc = 0; prev = 0;
    while (ng < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (mem_req && prev == 0) begin
        got[ng] = (mem_be == 4'h1) ? 1 : 0;
        gcyc[ng] = cyc;
        if (ng == 3) chk("starve_streak_max", 32'(dut.streak), 32'd4);
        if (ng == 4) chk("starve_streak_after_i", 32'(dut.streak), 32'd0);
        ng++;
      end
      prev = mem_req ? 1 : 0;
    end
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("starve_grant%0d_is_d", k), got[k], (k % 5 == 4) ? 0 : 1);
    end
    chk("starve_throughput", gcyc[1] - gcyc[0], 3);
    drain();

    // Stale request held through RESP must not re-issue until the following IDLE.
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h0000_0060; mem_rdata = 32'h0000_0abc; mem_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      mr[c] = mem_req;
      if (c == 2) chk("stale_i_ready_resp", {31'd0, i_ready}, 32'd1);
    end
    chk("stale_mem_req_pattern", {28'd0, mr[1], mr[2], mr[3], mr[4]}, 32'b1001);
    drain();

    // Asynchronous reset during the second BUSY cycle of a store.
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0500; d_wdata = 32'h0F0F_0F0F; d_be = 4'hF;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_busy_before", {30'd0, mem_req, mem_we}, 32'b11);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_mem_req_we", {30'd0, mem_req, mem_we}, 32'd0);
    chk("rstmid_readys", {30'd0, i_ready, d_ready}, 32'd0);
    chk("rstmid_mem_addr", mem_addr, 32'd0);
    d_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_after_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rstmid_after_state", int'(dut.state), 0);

    chk("ready_exclusive", {31'd0, both_hi}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
